// File: rtl/insn_sequencer.sv
// insn_sequencer: multicycle RV32I control FSM with memory req/ready handshake.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes instead of treating them as NOPs.
module insn_sequencer #(
  parameter int RESET_WAIT = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] insn,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_load,
  output logic        pc_we,
  output logic        rd_we,
  output logic [5:0]  insn_class,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        bus_err
);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [3:0] WAIT_INIT = 4'(RESET_WAIT);
  localparam logic [4:0] TO_LIM    = 5'(TIMEOUT);

  logic [3:0] wait_cnt;
  logic [4:0] to_cnt;
  logic       is_load;
  logic       is_store;
  logic       to_wb;
  logic [5:0] dec_class;
  logic       dec_load;
  logic       dec_store;
  logic       dec_wb;
  logic       dec_ill;
  logic       stall;
  logic       to_hit;
  logic       insn_unused;

  // Only the opcode field steers sequencing; the rest belongs to the datapath.
  assign insn_unused = ^insn[31:7];

  always_comb begin
    dec_class = 6'b000000;
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_wb    = 1'b0;
    dec_ill   = 1'b0;
    unique case (insn[6:0])
      OP_R: begin
        dec_class = 6'b000001;
        dec_wb    = 1'b1;
      end
      OP_IMM, OP_JALR: begin
        dec_class = 6'b000010;
        dec_wb    = 1'b1;
      end
      OP_LOAD: begin
        dec_class = 6'b000010;
        dec_load  = 1'b1;
      end
      OP_STORE: begin
        dec_class = 6'b000100;
        dec_store = 1'b1;
      end
      OP_BRANCH: dec_class = 6'b001000;
      OP_LUI, OP_AUIPC: begin
        dec_class = 6'b010000;
        dec_wb    = 1'b1;
      end
      OP_JAL: begin
        dec_class = 6'b100000;
        dec_wb    = 1'b1;
      end
      OP_FENCE, OP_SYS: dec_class = 6'b000000;
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    mem_req = ((state == S_FETCH) && run) || (state == S_MEM);
    stall   = mem_req && !mem_ready;
    to_hit  = (TIMEOUT != 0) && stall && (to_cnt == TO_LIM - 5'd1);
    mem_we  = (state == S_MEM) && is_store;
    ir_load = (state == S_FETCH) && run && mem_ready;
    rd_we   = (state == S_WB);
    pc_we   = rd_we
            || ((state == S_EXEC) && !is_load && !is_store && !to_wb)
            || ((state == S_MEM) && is_store && mem_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_WAIT;
      wait_cnt   <= WAIT_INIT;
      to_cnt     <= '0;
      insn_class <= '0;
      is_load    <= 1'b0;
      is_store   <= 1'b0;
      to_wb      <= 1'b0;
      illegal    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      // Counter is zero whenever no request is stalled, so it restarts per phase.
      to_cnt <= stall ? to_cnt + 5'd1 : '0;
      if (to_hit) begin
        bus_err <= 1'b1;
        state   <= S_TRAP;
      end else begin
        case (state)
          S_WAIT: begin
            if (wait_cnt == 4'd0) state <= S_FETCH;
            else wait_cnt <= wait_cnt - 4'd1;
          end
          S_FETCH: if (ir_load) state <= S_DECODE;
          S_DECODE: begin
            insn_class <= dec_class;
            is_load    <= dec_load;
            is_store   <= dec_store;
            to_wb      <= dec_wb;
            illegal    <= illegal | dec_ill;
`ifdef ILLEGAL_TRAP_EN
            state      <= dec_ill ? S_TRAP : S_EXEC;
`else
            state      <= S_EXEC;
`endif
          end
          S_EXEC: begin
            if (is_load || is_store) state <= S_MEM;
            else if (to_wb) state <= S_WB;
            else state <= S_FETCH;
          end
          S_MEM: if (mem_ready) state <= is_load ? S_WB : S_FETCH;
          S_WB: state <= S_FETCH;
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_insn_sequencer.sv
// tb_insn_sequencer: directed plus random instruction streams against a phase-list model.
// Honours ILLEGAL_TRAP_EN for the illegal-opcode scenario.
module tb_insn_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] insn;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        ir_load;
  logic        pc_we;
  logic        rd_we;
  logic [5:0]  insn_class;
  logic [2:0]  state;
  logic        illegal;
  logic        bus_err;

  int n_chk = 0;
  int n_fail = 0;
  logic [5:0] exp_cls;
  logic       exp_ill;

  localparam int PF = 1, PD = 2, PE = 3, PM = 4, PW = 5;
  localparam int K_LOAD = 0, K_STORE = 1, K_WB = 2, K_PC = 3, K_ILL = 4;

  logic [6:0] ops [13] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73, 7'h7F, 7'h0B};

  insn_sequencer #(.RESET_WAIT(2), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run), .insn(insn),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .ir_load(ir_load), .pc_we(pc_we), .rd_we(rd_we),
    .insn_class(insn_class), .state(state),
    .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input logic [6:0] op);
    case (op)
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b0110011, 7'b0010011, 7'b1100111,
      7'b0110111, 7'b0010111, 7'b1101111: return K_WB;
      7'b1100011, 7'b0001111, 7'b1110011: return K_PC;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [5:0] cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return 6'b000001;
      7'b0010011, 7'b0000011, 7'b1100111: return 6'b000010;
      7'b0100011: return 6'b000100;
      7'b1100011: return 6'b001000;
      7'b0110111, 7'b0010111: return 6'b010000;
      7'b1101111: return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  // Called at a negedge while reset is high; leaves the DUT in FETCH.
  task automatic bring_up();
    reset = 1'b0;
    exp_cls = '0;
    exp_ill = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_state", state, 0);
      chk("wait_mem_req", mem_req, 0);
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("first_fetch_state", state, PF);
    chk("first_fetch_req", mem_req, 1);
  endtask

  // rmode: 0 = ready always, 1 = random ready, 2 = 3 stall cycles in MEM
  task automatic do_insn(input logic [31:0] w, input int rmode,
                         output int cyc);
    int ph[$];
    int k;
    int waits;
    int kd;
    logic r;
    logic mp;
    logic last;
    kd = kind_of(w[6:0]);
    ph = '{PF, PD, PE};
    if (kd == K_LOAD) begin
      ph.push_back(PM);
      ph.push_back(PW);
    end else if (kd == K_STORE) begin
      ph.push_back(PM);
    end else if (kd == K_WB) begin
      ph.push_back(PW);
    end
    cyc = 0;
    k = 0;
    waits = 0;
    while (k < ph.size()) begin
      mp = (ph[k] == PF) || (ph[k] == PM);
      if (rmode == 0) r = 1'b1;
      else if (rmode == 2) r = !((ph[k] == PM) && (waits < 3));
      else r = ($urandom_range(0, 2) != 0) || (waits >= 4);
      mem_ready = r;
      insn = w;
      #1;
      last = (k == ph.size() - 1) && (!mp || r);
      chk("state", state, ph[k]);
      chk("mem_req", mem_req, mp);
      chk("mem_we", mem_we, (ph[k] == PM) && (kd == K_STORE));
      chk("ir_load", ir_load, (ph[k] == PF) && r);
      chk("pc_we", pc_we, last);
      chk("rd_we", rd_we, ph[k] == PW);
      chk("insn_class", insn_class, exp_cls);
      chk("illegal", illegal, exp_ill);
      chk("bus_err", bus_err, 0);
      @(posedge clk);
      if (ph[k] == PD) begin
        exp_cls = cls_of(w[6:0]);
        if (kd == K_ILL) exp_ill = 1'b1;
      end
      if (!mp || r) begin
        k++;
        waits = 0;
      end else begin
        waits++;
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    int idx;
    logic [31:0] rnd;
    reset = 1'b1;
    run = 1'b1;
    mem_ready = 1'b1;
    insn = '0;
    exp_cls = '0;
    exp_ill = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ir_load", ir_load, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_rd_we", rd_we, 0);
    chk("rst_class", insn_class, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_bus_err", bus_err, 0);
    bring_up();

    do_insn(32'h008000EF, 0, cyc);
    chk("jal_cycles", cyc, 4);
    chk("jal_class", insn_class, 6'b100000);
    do_insn(32'h0000A103, 2, cyc);
    chk("lw_cycles", cyc, 8);
    do_insn(32'h00208463, 0, cyc);
    chk("beq_cycles", cyc, 3);
    chk("beq_class", insn_class, 6'b001000);
`ifndef ILLEGAL_TRAP_EN
    do_insn(32'hFFFFFFFF, 0, cyc);
    chk("ill_cycles", cyc, 3);
    chk("ill_flag", illegal, 1);
`endif

    for (int n = 0; n < 40; n++) begin
`ifdef ILLEGAL_TRAP_EN
      idx = $urandom_range(0, 10);
`else
      idx = $urandom_range(0, 12);
`endif
      rnd = $urandom();
      do_insn({rnd[31:7], ops[idx]}, 1, cyc);
    end

    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("park_state", state, PF);
      chk("park_mem_req", mem_req, 0);
      chk("park_ir_load", ir_load, 0);
      @(posedge clk);
      @(negedge clk);
    end
    run = 1'b1;

`ifdef ILLEGAL_TRAP_EN
    insn = 32'hFFFFFFFF;
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("trap_state", state, 7);
      chk("trap_illegal", illegal, 1);
      chk("trap_pc_we", pc_we, 0);
      chk("trap_rd_we", rd_we, 0);
      chk("trap_mem_req", mem_req, 0);
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    chk("trap_rst_illegal", illegal, 0);
    @(negedge clk);
    bring_up();
`endif

    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("to_state", state, PF);
      chk("to_mem_req", mem_req, 1);
      chk("to_bus_err", bus_err, 0);
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("to_trap_state", state, 7);
    chk("to_trap_bus_err", bus_err, 1);
    chk("to_trap_mem_req", mem_req, 0);
    mem_ready = 1'b1;
    #1;
    chk("to_trap_ir_load", ir_load, 0);
    reset = 1'b1;
    #1;
    chk("to_rst_bus_err", bus_err, 0);
    chk("to_rst_state", state, 0);
    @(negedge clk);
    bring_up();

    insn = 32'h00112023;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    chk("sw_mem_state", state, PM);
    chk("sw_mem_req", mem_req, 1);
    chk("sw_mem_we", mem_we, 1);
    chk("sw_class", insn_class, 6'b000100);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_state", state, 0);
    chk("abort_mem_req", mem_req, 0);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_pc_we", pc_we, 0);
    chk("abort_class", insn_class, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
